addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised, multi-cycle two's-complement adder/subtractor with a valid/ready handshake on both sides. It processes one CHUNK-bit slice per clock, rippling the carry between cycles through a register. It reports carry, signed overflow, zero and negative flags, and optionally saturates signed results. It is the sequential, width-generic successor to the 4-bit combinational add/sub unit, for datapaths where a full-width ripple does not fit in one clock.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per clock. N = WIDTH/CHUNK. WIDTH%CHUNK != 0 is an elaboration error.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept an operation (registered).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  1  0: s = a + b; 1: s = a - b (a + ~b + 1).
- sat  input  1  1: clamp the signed result on overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  result, post-saturation.
- cout  output  1  raw carry out of the MSB. For subtraction, 1 means no borrow (a >= b unsigned).
- ovf  output  1  raw signed overflow, pre-saturation.
- zero  output  1  s == 0 (post-saturation).
- neg  output  1  s[WIDTH-1] (post-saturation).

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers: chunk index idx (0..N-1), carry register, latched a, latched bx = b ^ {WIDTH{mode}}, latched mode and sat.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: latch operands, set carry = mode, set idx = 0, drop in_ready, go to RUN.
- **RUN**, once per cycle:
  - Compute slice idx: {c, sum} = a[slice] + bx[slice] + carry.
  - Write sum into s[slice]; carry <= c; idx <= idx + 1. The LSB slice goes first.
- **RUN, on the idx = N-1 cycle**, additionally:
  - cout <= c.
  - ovf <= (a_msb == bx_msb) & (sum_msb != a_msb).
  - If sat & ovf: s <= a_msb ? {1'b1, {WIDTH-1{1'b0}}} : {1'b0, {WIDTH-1{1'b1}}}.
  - zero and neg are registered from the final s.
  - Go to DONE.
- **DONE**
  - out_valid = 1; s and the flags are held stable.
  - On out_valid & out_ready: drop out_valid, raise in_ready, go to IDLE.
- Operands are latched at acceptance. Changes on a, b, mode or sat afterwards have no effect on the operation in flight.
- Only one operation is in flight at a time. in_valid outside IDLE is ignored.
- During RUN, s holds partial results. They are only meaningful while out_valid = 1.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready = 0, out_valid = 0, s = 0, cout = 0, ovf = 0, zero = 0, neg = 0; idx and carry are cleared.
- in_ready rises on the first rising edge after rst_n deasserts.
- Accept at edge E0. Slices are computed at edges E1..EN. out_valid is high after EN. Latency is N cycles.
- Result taken at edge Ek (out_valid & out_ready): in_ready = 1 after Ek. The next accept is possible at Ek+1.
- Best-case throughput is one operation per N+2 cycles.
- out_ready may be held high in advance; the result is then taken on the first DONE cycle.
- CHUNK == WIDTH gives N = 1: a single RUN cycle.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No out_valid is produced and all outputs return to reset values.
- The carry register is the only inter-slice path. The combinational depth is one CHUNK-bit adder.

## Test plan
Parameters for all scenarios: WIDTH=16, CHUNK=4, so N=4.
1. Basic add and latency: a=0x0003, b=0x0001, mode=0, sat=0 -> s=0x0004, cout=0, ovf=0, zero=0, neg=0. out_valid rises exactly 4 edges after acceptance.
2. Subtract:
   - 0x0009 - 0x0008 -> s=0x0001, cout=1, neg=0.
   - 0x0003 - 0x0009 -> s=0xFFFA, cout=0, neg=1, ovf=0.
3. Inter-chunk carry ripple:
   - 0x0FFF + 0x0001 -> s=0x1000, cout=0.
   - 0xFFFF + 0x0001 -> s=0x0000, cout=1, zero=1.
4. Overflow and saturation:
   - 0x7FFF + 0x0001, sat=0 -> s=0x8000, ovf=1, neg=1.
   - Same operands, sat=1 -> s=0x7FFF, ovf=1, neg=0.
   - 0x8000 - 0x0001, sat=1 -> s=0x8000, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> out_valid, s and flags stay stable, in_ready=0, the new operands are not accepted. Raise out_ready -> in_ready=1 next cycle.
6. Reset mid-RUN: assert rst_n=0 at the second RUN cycle -> all outputs 0 immediately. After release, in_ready=1 one edge later, and 0x1234 + 0x4321 then yields s=0x5555.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per clock,
// carry rippled through a register, valid/ready on both sides, optional saturation.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("addsub_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   bx_q;
  logic               sat_q;

  logic               accept;
  logic               take;
  logic               last;
  logic [CHUNK-1:0]   a_sl;
  logic [CHUNK-1:0]   bx_sl;
  logic [CHUNK-1:0]   sum;
  logic               c;
  logic               ovf_c;
  logic [WIDTH-1:0]   s_full;
  logic [WIDTH-1:0]   s_fin;

  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign take      = (state == DONE) && out_ready;
  assign last      = (idx == IDX_W'(N - 1));
  assign out_valid = (state == DONE);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)       state_next = RUN;
      RUN:     if (last)         state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // One CHUNK-bit adder is the only combinational depth; the slice is spliced
  // into the running result, and clamped on the final slice if saturating.
  always_comb begin
    a_sl          = a_q[idx*CHUNK +: CHUNK];
    bx_sl         = bx_q[idx*CHUNK +: CHUNK];
    {c, sum}      = {1'b0, a_sl} + {1'b0, bx_sl} + {{CHUNK{1'b0}}, carry};
    s_full        = s;
    s_full[idx*CHUNK +: CHUNK] = sum;
    ovf_c         = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
    s_fin         = s_full;
    if (last && sat_q && ovf_c)
      s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: operand latches need no reset value (they are always written at
  // acceptance before use); they are cleared anyway to keep reset state clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      bx_q     <= '0;
      sat_q    <= 1'b0;
      s        <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            bx_q     <= b ^ {WIDTH{mode}};
            sat_q    <= sat;
            carry    <= mode;
            idx      <= '0;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          s     <= s_fin;
          carry <= c;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            cout <= c;
            ovf  <= ovf_c;
            zero <= (s_fin == '0);
            neg  <= s_fin[WIDTH-1];
          end
        end
        DONE: begin
          if (take) in_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (WIDTH=16, CHUNK=4): directed table,
// multi-cycle corner sequences, and randomized ops against an arithmetic model.
module tb_addsub_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             mode, sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout, ovf, zero, neg;

  addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             sat;
    res_t             exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string name, input res_t act, input res_t exp);
    check({name, ".s"},    32'(act.s),    32'(exp.s));
    check({name, ".cout"}, 32'(act.cout), 32'(exp.cout));
    check({name, ".ovf"},  32'(act.ovf),  32'(exp.ovf));
    check({name, ".zero"}, 32'(act.zero), 32'(exp.zero));
    check({name, ".neg"},  32'(act.neg),  32'(exp.neg));
  endtask

  // Reference: whole-word integer arithmetic, then clamp to the signed range.
  function automatic res_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                 input logic md, input logic st);
    res_t r;
    int   sa, sb, sr;
    int   ua, ub;
    sa = int'($signed(ai));
    sb = int'($signed(bi));
    ua = int'(ai);
    ub = int'(bi);
    sr = md ? sa - sb : sa + sb;
    r.cout = md ? (ua >= ub) : ((ua + ub) >= (1 << WIDTH));
    r.ovf  = (sr > (1 << (WIDTH-1)) - 1) || (sr < -(1 << (WIDTH-1)));
    if (st && r.ovf) sr = (sr > 0) ? (1 << (WIDTH-1)) - 1 : -(1 << (WIDTH-1));
    r.s    = WIDTH'(sr);
    r.zero = (r.s == '0);
    r.neg  = r.s[WIDTH-1];
    return r;
  endfunction

  function automatic res_t outs();
    res_t r;
    r.s = s; r.cout = cout; r.ovf = ovf; r.zero = zero; r.neg = neg;
    return r;
  endfunction

  // Accept one operation, wait for the result, take it. Inputs are scrambled
  // right after acceptance so latching is exercised.
  task automatic do_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic md, input logic st, input string name,
                       output res_t got, output int lat);
    int g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ai; b = bi; mode = md; sat = st; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); mode = ~md; sat = ~st;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    got = outs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ".ov_drop"}, 32'(out_valid), 32'd0);
    check({name, ".ir_back"}, 32'(in_ready),  32'd1);
  endtask

  vec_t vecs[10];
  res_t got, hold, exp;
  int   lat;

  initial begin
    vecs[0] = '{16'h0003, 16'h0001, 1'b0, 1'b0, '{16'h0004, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{16'h0009, 16'h0008, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{16'h0003, 16'h0009, 1'b1, 1'b0, '{16'hFFFA, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0, 1'b1}};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0, 1'b1}};
    vecs[9] = '{16'h1234, 16'h1234, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 1'b0; sat = 1'b0;

    // Reset values, and in_ready only after the first edge past release.
    #1;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_res("rst", outs(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rel.in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rel.in_ready_high", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sat, $sformatf("vec%0d", i), got, lat);
      check($sformatf("vec%0d.latency", i), 32'(lat), 32'(N));
      check_res($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Backpressure: result held for 5 cycles while new operands are offered.
    a = 16'h0009; b = 16'h0008; mode = 1'b1; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp.latency", 32'(lat), 32'(N));
    hold = outs();
    check_res("bp.first", hold, '{16'h0001, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 5; k++) begin
      a = 16'h7FFF; b = 16'h7FFF; mode = 1'b0; sat = 1'b1;
      in_valid = (k % 2 == 0);
      @(posedge clk); #1;
      check($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d.in_ready", k),  32'(in_ready),  32'd0);
      check_res($sformatf("bp%0d", k), outs(), hold);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.take.out_valid", 32'(out_valid), 32'd0);
    check("bp.take.in_ready",  32'(in_ready),  32'd1);
    // Still idle: the offered operands were never accepted.
    @(posedge clk); #1;
    check("bp.idle.out_valid", 32'(out_valid), 32'd0);
    check("bp.idle.in_ready",  32'(in_ready),  32'd1);

    // out_ready held high in advance: result taken on first DONE cycle.
    out_ready = 1'b1;
    a = 16'h0FFF; b = 16'h0001; mode = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    check("early.out_valid", 32'(out_valid), 32'd1);
    check("early.s", 32'(s), 32'h1000);
    @(posedge clk); #1;
    check("early.taken", 32'(out_valid), 32'd0);
    check("early.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Reset during the second RUN cycle aborts the operation.
    a = 16'hFFFF; b = 16'hFFFF; mode = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid.in_ready",  32'(in_ready),  32'd0);
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check_res("mid", outs(), '0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("mid.rel.in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("mid.rel.in_ready_high", 32'(in_ready), 32'd1);
    check("mid.rel.no_result", 32'(out_valid), 32'd0);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, "post_rst", got, lat);
    check("post_rst.latency", 32'(lat), 32'(N));
    check_res("post_rst", got, '{16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});

    // Randomized ops against the arithmetic model, biased toward edge values.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rm, rs;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001;
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      exp = model(ra, rb, rm, rs);
      do_op(ra, rb, rm, rs, $sformatf("rnd%0d", i), got, lat);
      check($sformatf("rnd%0d.latency", i), 32'(lat), 32'(N));
      check_res($sformatf("rnd%0d", i), got, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
